// File: rtl/imem_responder.sv
// Instruction-memory responder: serves one fetch at a time over valid/ready,
// returning the addressed word after LATENCY wait states, with flush and a preload port.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Word offsets are taken on the full 32-bit difference; the whole shifted
  // value feeds the range check so the index truncation cannot alias.
  logic [31:0]   req_word, load_word;
  logic          req_err, load_ok, accept;
  logic [AW-1:0] req_idx, load_idx;

  assign req_word  = (req_addr - BASE_ADDR) >> 2;
  assign req_idx   = req_word[AW-1:0];
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                     ((req_word >> AW) != 32'd0);

  assign load_word = (load_addr - BASE_ADDR) >> 2;
  assign load_idx  = load_word[AW-1:0];
  assign load_ok   = (load_addr[1:0] == 2'b00) && (load_addr >= BASE_ADDR) &&
                     ((load_word >> AW) == 32'd0);

  assign req_ready  = ((state_q == IDLE) || ((state_q == RESP) && resp_ready)) && !flush;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) state_d = IDLE;
        end
        default: ;
      endcase
      // A new accept overrides the handshake exit, giving back-to-back service.
      if (accept) begin
        rdata_d = req_err ? 32'd0 : mem[req_idx];
        err_d   = req_err;
        cnt_d   = LAT;
        state_d = (LAT != 4'd0) ? WAIT : RESP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; a same-edge read captures the pre-write word.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) mem[load_idx] <= load_data;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder: the memory-side end of the fetch interface that the fetch stage drives. It accepts one fetch request at a time on a valid/ready handshake. It returns the addressed 32-bit word after a parameterised number of wait states and holds the response until the fetch side takes it. It supports a flush for branch redirects and a write-only load port for program preload.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored (power of two, 16..65536)
LATENCY, 2, extra wait-state cycles between request acceptance and response (0..15)
BASE_ADDR, 32'h00000000, byte address of word 0 (word-aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address of instruction to fetch
resp_valid  output  1  response word available
resp_ready  input  1  fetch side consumes response this cycle
resp_rdata  output  32  fetched instruction word
resp_err  output  1  request was misaligned or out of range
flush  input  1  cancel any pending or held response (branch redirect)
load_en  input  1  write enable for preload port
load_addr  input  32  byte address for preload write
load_data  input  32  word to write

Behaviour:
- Reset: state=IDLE, req_ready=1 once reset deasserts, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory contents are not reset. Reset mid-transaction drops it silently.
- States: IDLE, WAIT, RESP.
- Accept = req_valid && req_ready.
- req_ready = (state==IDLE) || (state==RESP && resp_ready), and is forced 0 when flush=1. This is a combinational path from resp_ready and flush.
- On accept, at the same edge:
  - Compute word index = (req_addr-BASE_ADDR)>>2.
  - err = (req_addr[1:0]!=0) || req_addr<BASE_ADDR || index>=DEPTH_WORDS.
  - Latch rdata = err ? 0 : mem[index]; latch err.
  - Load counter with LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT: counter decrements each cycle; when it reaches 1, next state is RESP. resp_valid=1 exactly LATENCY+1 cycles after the accept edge.
- RESP: resp_valid=1; resp_rdata and resp_err are stable until the handshake.
  - On resp_valid && resp_ready with no new accept: IDLE, resp_valid=0.
  - With a simultaneous accept: process the new request as above (back-to-back). With LATENCY=0 this sustains one word per cycle.
- flush (highest priority after reset): from WAIT or RESP, next state is IDLE. resp_valid=0 next cycle, resp_rdata/resp_err cleared to 0, no accept that cycle. A response handshake coinciding with flush is still considered consumed. flush in IDLE has no effect beyond blocking acceptance.
- Load port: independent of FSM. If load_en, aligned and in range, mem[index] <= load_data at the edge. Misaligned or out-of-range loads are ignored.
- Read/load same word same edge as accept: the response returns the old data (read-before-write). A load during WAIT does not alter the latched response.
- Address arithmetic is unsigned 32-bit; index uses bits [log2(DEPTH_WORDS)+1:2] after the range check.

Test Plan:
1. Preload mem[0..3]=32'hE3A00001..04; LATENCY=2; request addr 0x4 -> resp_valid rises 3 cycles after accept, rdata=32'hE3A00002, err=0; held 4 cycles with resp_ready=0 unchanged.
2. LATENCY=0; req_valid and resp_ready held high; addrs 0x0,0x4,0x8,0xC -> one response per cycle, data in order, req_ready continuously 1 after the first accept.
3. Request addr 0x6, then addr 0x1000 with DEPTH_WORDS=1024 -> each returns err=1, rdata=0; FSM returns to IDLE after handshake.
4. Accept addr 0x8 (LATENCY=2); assert flush in first WAIT cycle -> no resp_valid ever; next request to 0xC accepted normally and returns mem[3].
5. Same edge: accept addr 0x0 and load_en to 0x0 with 32'hDEADBEEF -> response = old 32'hE3A00001; subsequent fetch of 0x0 returns 32'hDEADBEEF.
6. Assert reset during RESP -> resp_valid=0, rdata=0, err=0 immediately (asynchronous); memory contents preserved on the next fetch.
